// File: rtl/demux_pkg.sv
// Shared types and sizes for the serial-to-parallel demultiplexer.
// Optional feature macro: DEMUX_PARITY_EN (adds a 17th even-parity bit per frame).
package demux_pkg;

   localparam int WORD_W = 16;
   localparam int SEL_W  = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
`ifdef DEMUX_PARITY_EN
      PARITY = 2'd2,
`endif
      FULL   = 2'd3
   } state_t;

endpackage

// File: rtl/demux_sel_cnt.sv
// Write-index counter for the assembly buffer: wraps 15 -> 0.
// Ports: clk, rst (sync clear), load1 (restart at index 1), inc, cnt.
module demux_sel_cnt
   import demux_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load1,
   input  logic             inc,
   output logic [SEL_W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load1) begin
         cnt <= SEL_W'(1);
      end else if (inc) begin
         cnt <= cnt + SEL_W'(1);
      end
   end

endmodule

// File: rtl/demux_deser.sv
// Serial bit stream in (valid/ready), 16-bit word out (valid/ready), LSB first.
// Ports: clk, rst, in_bit, in_valid, in_ready, frame_start, out, out_valid,
// out_ready, sel_cnt, parity_err (only with macro DEMUX_PARITY_EN).
module demux_deser
   import demux_pkg::*;
#(
   parameter bit OUT_CLEAR = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_bit,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              frame_start,
   output logic [WORD_W-1:0] out,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [SEL_W-1:0]  sel_cnt
`ifdef DEMUX_PARITY_EN
   ,
   output logic              parity_err
`endif
);

   state_t            state_q;
   state_t            state_d;
   logic [WORD_W-1:0] asm_q;
   logic [WORD_W-1:0] asm_nxt;

   logic in_xfer;
   logic out_xfer;
   logic restart;
   logic data_bit;
   logic last_data;
   logic complete;
   logic free;
   logic load_now;
   logic to_full;
   logic full_load;

`ifdef DEMUX_PARITY_EN
   logic err_now;
   logic err_q;
`endif

   always_comb begin
      in_xfer   = in_valid && in_ready;
      out_xfer  = out_valid && out_ready;
      // in_ready is low in FULL, so frame_start is ignored there for free
      restart   = in_xfer && frame_start;
`ifdef DEMUX_PARITY_EN
      data_bit  = in_xfer && !frame_start && (state_q != PARITY);
      complete  = in_xfer && !frame_start && (state_q == PARITY);
`else
      data_bit  = in_xfer && !frame_start;
      complete  = 1'b0;
`endif
      last_data = data_bit && (sel_cnt == SEL_W'(WORD_W - 1));
`ifndef DEMUX_PARITY_EN
      complete  = last_data;
`endif
      // output register can take a word if empty or emptied this cycle
      free      = !out_valid || out_ready;
      load_now  = complete && free;
      to_full   = complete && !free;
      full_load = (state_q == FULL) && out_xfer;
   end

   always_comb begin
      asm_nxt = asm_q;
      if (restart) begin
         asm_nxt    = '0;
         asm_nxt[0] = in_bit;
      end else if (data_bit) begin
         asm_nxt[sel_cnt] = in_bit;
      end
   end

`ifdef DEMUX_PARITY_EN
   // even parity over data and parity bit; 1 means error
   assign err_now = (^asm_q) ^ in_bit;
`endif

   demux_sel_cnt u_sel (
      .clk   (clk),
      .rst   (rst),
      .load1 (restart),
      .inc   (data_bit),
      .cnt   (sel_cnt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, SHIFT: begin
            if (restart) begin
               state_d = SHIFT;
            end else if (last_data) begin
`ifdef DEMUX_PARITY_EN
               state_d = PARITY;
`else
               state_d = free ? IDLE : FULL;
`endif
            end else if (data_bit) begin
               state_d = SHIFT;
            end
         end
`ifdef DEMUX_PARITY_EN
         PARITY: begin
            if (restart) begin
               state_d = SHIFT;
            end else if (complete) begin
               state_d = free ? IDLE : FULL;
            end
         end
`endif
         FULL: begin
            if (out_xfer) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state_q != FULL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         asm_q     <= '0;
         out       <= '0;
         out_valid <= 1'b0;
`ifdef DEMUX_PARITY_EN
         parity_err <= 1'b0;
         err_q      <= 1'b0;
`endif
      end else begin
         asm_q <= asm_nxt;
         if (load_now) begin
            out       <= asm_nxt;
            out_valid <= 1'b1;
`ifdef DEMUX_PARITY_EN
            parity_err <= err_now;
`endif
         end else if (full_load) begin
            out       <= asm_q;
            out_valid <= 1'b1;
`ifdef DEMUX_PARITY_EN
            parity_err <= err_q;
`endif
         end else if (out_xfer) begin
            out_valid <= 1'b0;
            if (OUT_CLEAR) begin
               out <= '0;
            end
         end
`ifdef DEMUX_PARITY_EN
         // parity verdict waits here while the word sits in FULL
         if (to_full) begin
            err_q <= err_now;
         end
`endif
      end
   end

`ifndef DEMUX_PARITY_EN
   logic unused_ok;
   assign unused_ok = to_full;
`endif

endmodule

// File: tb/tb_demux_deser.sv
// Directed-vector bench for demux_deser.
// Covers reset, basic word, backpressure/FULL, frame_start, mid-frame reset.
module tb_demux_deser;

   logic        clk;
   logic        rst;
   logic        in_bit;
   logic        in_valid;
   logic        in_ready;
   logic        frame_start;
   logic [15:0] out;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  sel_cnt;
`ifdef DEMUX_PARITY_EN
   logic        parity_err;
`endif

   int n_vec;
   int n_bad;

   demux_deser #(.OUT_CLEAR(1'b0)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_bit      (in_bit),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .frame_start (frame_start),
      .out         (out),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .sel_cnt     (sel_cnt)
`ifdef DEMUX_PARITY_EN
      ,
      .parity_err  (parity_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input logic [15:0] w, input int lo,
                            input int hi, input logic fs);
      for (int i = lo; i <= hi; i++) begin
         in_valid    = 1'b1;
         in_bit      = w[i];
         frame_start = fs && (i == lo);
         tick();
      end
      frame_start = 1'b0;
   endtask

   initial begin
      n_vec       = 0;
      n_bad       = 0;
      rst         = 1'b1;
      in_bit      = 1'b0;
      in_valid    = 1'b0;
      frame_start = 1'b0;
      out_ready   = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_out", 32'(out), 32'h0);
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_sel", 32'(sel_cnt), 32'h0);
      chk("rst_ready", 32'(in_ready), 32'h1);

      // basic word, consumer always ready
      out_ready = 1'b1;
      send_bits(16'hA5C3, 0, 14, 1'b0);
      chk("a5_pre_valid", 32'(out_valid), 32'h0);
      chk("a5_pre_sel", 32'(sel_cnt), 32'd15);
      send_bits(16'hA5C3, 15, 15, 1'b0);
      in_valid = 1'b0;
      chk("a5_out", 32'(out), 32'hA5C3);
      chk("a5_valid", 32'(out_valid), 32'h1);
      chk("a5_sel_wrap", 32'(sel_cnt), 32'h0);
      tick();
      chk("a5_valid_drop", 32'(out_valid), 32'h0);
      chk("a5_out_hold", 32'(out), 32'hA5C3);

      // backpressure: second word parks in FULL
      out_ready = 1'b0;
      send_bits(16'h1234, 0, 15, 1'b0);
      chk("bp_w1_out", 32'(out), 32'h1234);
      chk("bp_w1_valid", 32'(out_valid), 32'h1);
      send_bits(16'hBEEF, 0, 15, 1'b0);
      chk("bp_full_ready", 32'(in_ready), 32'h0);
      chk("bp_full_out", 32'(out), 32'h1234);
      in_valid = 1'b1;
      in_bit   = 1'b1;
      tick();
      tick();
      in_valid = 1'b0;
      chk("bp_full_sel", 32'(sel_cnt), 32'h0);
      chk("bp_stable_out", 32'(out), 32'h1234);
      chk("bp_stable_valid", 32'(out_valid), 32'h1);
      out_ready = 1'b1;
      tick();
      chk("bp_w2_out", 32'(out), 32'hBEEF);
      chk("bp_w2_valid", 32'(out_valid), 32'h1);
      chk("bp_w2_ready", 32'(in_ready), 32'h1);
      tick();
      chk("bp_drain", 32'(out_valid), 32'h0);

      // frame_start discards a partial word
      send_bits(16'h001F, 0, 4, 1'b0);
      chk("fs_sel5", 32'(sel_cnt), 32'd5);
      send_bits(16'h0001, 0, 0, 1'b1);
      chk("fs_sel1", 32'(sel_cnt), 32'd1);
      send_bits(16'h0001, 1, 15, 1'b0);
      in_valid = 1'b0;
      chk("fs_out", 32'(out), 32'h0001);
      chk("fs_valid", 32'(out_valid), 32'h1);
      tick();

      // reset mid-frame
      send_bits(16'hFFFF, 0, 8, 1'b0);
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mr_sel", 32'(sel_cnt), 32'h0);
      chk("mr_valid", 32'(out_valid), 32'h0);
      chk("mr_out", 32'(out), 32'h0);
      send_bits(16'hFFFF, 0, 15, 1'b0);
      in_valid = 1'b0;
      chk("mr_ffff", 32'(out), 32'hFFFF);
      tick();
      chk("mr_drain", 32'(out_valid), 32'h0);

      // last bit coincides with delivery of the previous word
      out_ready = 1'b0;
      send_bits(16'h00F0, 0, 15, 1'b0);
      send_bits(16'h0F0F, 0, 14, 1'b0);
      chk("bb_hold", 32'(out), 32'h00F0);
      out_ready = 1'b1;
      send_bits(16'h0F0F, 15, 15, 1'b0);
      in_valid = 1'b0;
      chk("bb_out", 32'(out), 32'h0F0F);
      chk("bb_valid", 32'(out_valid), 32'h1);
      chk("bb_ready", 32'(in_ready), 32'h1);
      tick();
      chk("bb_drain", 32'(out_valid), 32'h0);

`ifdef DEMUX_PARITY_EN
      // 0x0003 has two ones: parity 0 is correct
      send_bits(16'h0003, 0, 15, 1'b0);
      chk("par_sel", 32'(sel_cnt), 32'h0);
      send_bits(16'h0000, 0, 0, 1'b0);
      in_valid = 1'b0;
      chk("par_ok_out", 32'(out), 32'h0003);
      chk("par_ok_err", 32'(parity_err), 32'h0);
      tick();
      // 0x0001 has one one: parity 0 is wrong
      send_bits(16'h0001, 0, 15, 1'b0);
      send_bits(16'h0000, 0, 0, 1'b0);
      in_valid = 1'b0;
      chk("par_bad_out", 32'(out), 32'h0001);
      chk("par_bad_err", 32'(parity_err), 32'h1);
      tick();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
